// File: rtl/regfile_sb_pkg.sv
// Shared constants and state encoding for the scoreboarded register file.
package regfile_sb_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_NUM_RD     = 2;
    localparam int DEF_CNT_W      = 2;

    localparam int ZERO_REG = 0;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_sb_cnt.sv
// Saturating up/down pending-write counter for one register.
module regfile_sb_cnt #(
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic nonzero,
    output logic one
);

    logic [CNT_W-1:0] cnt;
    logic             dec_eff;

    // A release with nothing pending is a plain write: no underflow.
    assign dec_eff = dec && nonzero;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (inc && !dec_eff && !full) begin
            cnt <= cnt + CNT_W'(1);
        end else if (dec_eff && !inc) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign full    = &cnt;
    assign nonzero = |cnt;
    assign one     = (cnt == CNT_W'(1));

endmodule

// File: rtl/regfile_sb.sv
// Register file with write bypass, r0 hardwired to zero, post-reset clear
// sequencer and a per-register pending-write scoreboard.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int NUM_RD     = DEF_NUM_RD,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
    output logic [NUM_RD-1:0]            rbusy,
    input  logic                         wen,
    input  logic [ADDR_WIDTH-1:0]        waddr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic                         iss_valid,
    input  logic [ADDR_WIDTH-1:0]        iss_addr,
    output logic                         iss_ready,
    output logic                         init_done
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   ptr;
    logic                    run;
    logic                    wr_live;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]        full_v;
    logic [DEPTH-1:0]        nz_v;
    logic [DEPTH-1:0]        one_v;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= INIT;
            ptr   <= ADDR_WIDTH'(1);
        end else if (state == INIT) begin
            ptr <= ptr + ADDR_WIDTH'(1);
            if (ptr == LAST_ADDR) begin
                state <= RUN;
            end
        end
    end

    assign run       = (state == RUN);
    assign init_done = run;
    assign wr_live   = run && wen && (waddr != ZERO_ADDR);

    // The clear sequencer owns the single write port until RUN.
    assign mem_we    = !run || wr_live;
    assign mem_addr  = run ? waddr : ptr;
    assign mem_wdata = run ? wdata : '0;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    assign full_v[0] = 1'b0;
    assign nz_v[0]   = 1'b0;
    assign one_v[0]  = 1'b0;

    // A saturated register may still accept a reservation if it is released this cycle.
    assign iss_ready = run && ((iss_addr == ZERO_ADDR) || !full_v[iss_addr] ||
                               (wen && (waddr == iss_addr)));

    for (genvar a = 1; a < DEPTH; a++) begin : g_cnt
        logic inc;
        logic dec;

        assign inc = run && iss_valid && iss_ready && (iss_addr == ADDR_WIDTH'(a));
        assign dec = run && wen && (waddr == ADDR_WIDTH'(a));

        regfile_sb_cnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk     (clk),
            .resetn  (resetn),
            .inc     (inc),
            .dec     (dec),
            .full    (full_v[a]),
            .nonzero (nz_v[a]),
            .one     (one_v[a])
        );
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic                  hit;

        assign ra  = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign hit = wr_live && (waddr == ra);

        assign rdata[i*DATA_WIDTH +: DATA_WIDTH] =
            (!run || ra == ZERO_ADDR) ? '0 : (hit ? wdata : mem[ra]);
        assign rbusy[i] = run && nz_v[ra] && !(hit && one_v[ra]);
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file with a per-register write-pending scoreboard for the five-stage MIPS pipeline. It provides NUM_RD combinational read ports with same-cycle write bypass and one write-back port, and it hardwires register 0 to zero. After reset, an internal sequencer clears the array one entry per cycle. Decode issues destination reservations through a valid/ready handshake, and write-back releases them. Decode uses the per-port busy flags to detect RAW hazards.

## Interface
Parameters:
- DATA_WIDTH, 32, register width
- ADDR_WIDTH, 5, address width; depth = 2**ADDR_WIDTH
- NUM_RD, 2, number of read ports (≥1)
- CNT_W, 2, width of each pending-write counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  reset; asynchronous and active-low
- raddr  in  NUM_RD*ADDR_WIDTH  read addresses; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- rdata  out  NUM_RD*DATA_WIDTH  read data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- rbusy  out  NUM_RD  port i addresses a register whose data is still pending
- wen  in  1  write-back enable; also releases one reservation
- waddr  in  ADDR_WIDTH  write-back address
- wdata  in  DATA_WIDTH  write-back data
- iss_valid  in  1  decode requests a reservation on iss_addr
- iss_addr  in  ADDR_WIDTH  destination register to reserve
- iss_ready  out  1  reservation accepted this cycle when iss_valid is also high
- init_done  out  1  array clear complete; block operational

## Operation
- Two states, INIT and RUN:
  - resetn low → INIT, clear pointer = 1, all pending counters = 0.
  - In INIT, each cycle writes 0 to reg[ptr] and increments ptr.
  - When ptr = 2**ADDR_WIDTH-1 is written, the next state is RUN.
  - RUN is held until reset.
- Reg 0 is never stored. Reads of address 0 return 0; writes to address 0 are discarded.
- In INIT:
  - wen and iss_valid are ignored.
  - iss_ready = 0, rbusy = 0, and all rdata = 0.
- Read port i in RUN:
  - If wen && waddr == raddr_i && waddr != 0, rdata_i = wdata (bypass).
  - Otherwise rdata_i = reg[raddr_i].
- Pending counter cnt[a] for a ≠ 0; cnt[0] is always 0:
  - inc = iss_valid && iss_ready && iss_addr == a
  - dec = wen && waddr == a && cnt[a] != 0
  - inc and dec together: no change. inc only: +1. dec only: −1.
  - wen to a register with cnt = 0: data is written and the counter stays at 0 (no underflow).
- iss_ready = init_done && (iss_addr == 0 || cnt[iss_addr] != 2**CNT_W-1 || (wen && waddr == iss_addr)).
  - A saturated counter accepts a reservation only when a release to the same register occurs in the same cycle.
  - iss_addr 0 is always accepted and not counted.
- rbusy_i = (cnt[raddr_i] != 0) && !(wen && waddr == raddr_i && cnt[raddr_i] == 1).
  - A same-cycle write-back of the last pending value clears busy through the bypass.
  - Reservations issued in the current cycle do not affect rbusy until the next cycle.

## Timing
- Reset values:
  - init_done = 0, iss_ready = 0, rbusy = 0, rdata = 0.
  - All counters = 0; FSM state = INIT.
  - Array contents are undefined until the clear completes.
- init_done rises 2**ADDR_WIDTH-1 rising edges after resetn deasserts (31 for the defaults).
- Reads and busy flags are combinational; there is zero-cycle latency, bypass included.
- Write data is visible through the array from the cycle after the write edge.
- A counter update is visible on rbusy and iss_ready in the cycle after the handshake edge.
- resetn assertion mid-operation, including mid-INIT, immediately forces every output to its reset value. The clear restarts from ptr = 1.

## Structure
- Shared package:
  - Default DATA_WIDTH, ADDR_WIDTH, NUM_RD and CNT_W constants
  - State encoding: INIT = 1'b0, RUN = 1'b1
  - ZERO_REG address constant
- One natural sub-module, regfile_sb_cnt: one saturating up/down counter with inc, dec, full and nonzero outputs.
  - The top instantiates 2**ADDR_WIDTH-1 of these in a generate loop.
- The array has no reset, so it maps to distributed RAM. Only the FSM, the pointer and the counters take resetn.

## Test plan
- Reset then idle:
  - init_done is 0 for exactly 31 cycles, then 1.
  - Every address reads 0, including values written before reset.
- Write 0xDEADBEEF to r5:
  - rdata0 shows 0xDEADBEEF in the same cycle when raddr0 = 5 (bypass), and in later cycles from the array.
  - Writing 0x1 to r0 still reads 0.
- Issue r7 twice:
  - rbusy = 1 on r7.
  - After the first wen to r7, rbusy stays 1. During the second wen cycle, rbusy = 0 and rdata carries wdata.
- Issue r3 three times (CNT_W = 2):
  - iss_ready = 0 on the next r3 request.
  - A request coinciding with wen to r3 is accepted and the count stays at 3.
- Assert resetn for one cycle mid-INIT, and later in RUN with reservations pending:
  - All counters are cleared and init_done drops.
  - The clear restarts and takes 31 cycles.
- wen to r9 with cnt = 0, plus a simultaneous issue and write to r9 with cnt = 1:
  - The data is written and the counter is 0 in the first case and stays 1 in the second.
